// File: rtl/riscv_imem_loader_pkg.sv
// Shared riscv definitions for the imem loader: bus widths, loader FSM encodings,
// byte-per-word constant and an address helper.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMEM_ADDR_BIT
`define IMEM_ADDR_BIT 12
`endif

package riscv_imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    // CHK only exists when the trailing checksum byte is built in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
        ST_CHK  = 3'd3,
`endif
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

    function automatic logic [`XLEN-1:0] word_byte_addr(
        input logic [`XLEN-1:0] base,
        input logic [`XLEN-1:0] word_idx
    );
        return base + (word_idx << 2);
    endfunction

endpackage

// File: rtl/riscv_imem_loader_if.sv
// Byte-stream input, imem write port and status flags of the imem loader.
// slave = loader side, master = stream source / imem / cpu side.
`ifndef XLEN
`define XLEN 32
`endif

interface riscv_imem_loader_if;
    logic               i_loader_start;
    logic               i_loader_valid;
    logic [7:0]         i_loader_byte;
    logic               o_loader_ready;
    logic               o_loader_imem_wr_en;
    logic [`XLEN-1:0]   o_loader_imem_addr;
    logic [`XLEN-1:0]   o_loader_imem_wr_data;
    logic               o_loader_cpu_rstn;
    logic               o_loader_done;
    logic               o_loader_err;

    modport slave (
        input  i_loader_start, i_loader_valid, i_loader_byte,
        output o_loader_ready, o_loader_imem_wr_en, o_loader_imem_addr,
               o_loader_imem_wr_data, o_loader_cpu_rstn, o_loader_done, o_loader_err
    );

    modport master (
        output i_loader_start, i_loader_valid, i_loader_byte,
        input  o_loader_ready, o_loader_imem_wr_en, o_loader_imem_addr,
               o_loader_imem_wr_data, o_loader_cpu_rstn, o_loader_done, o_loader_err
    );
endinterface

// File: rtl/riscv_imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, then
// releases the CPU reset. Define RISCV_IMEM_LOADER_CHKSUM_EN for a trailing sum byte.
module riscv_imem_loader
    import riscv_imem_loader_pkg::*;
#(
    parameter logic [`XLEN-1:0] LOAD_BASE = 32'h0000_0000,
    parameter int               MAX_WORDS = 1024
) (
    input  logic i_clk,
    input  logic i_rstn,
    riscv_imem_loader_if.slave bus
);

    localparam logic [`XLEN-1:0] MAX_WORDS_W = `XLEN'(MAX_WORDS);
    localparam logic [1:0]       LAST_BYTE   = 2'(BYTES_PER_WORD - 1);

    loader_state_t      state_reg, state_next;
    logic [1:0]         byte_cnt_reg, byte_cnt_next;
    logic [`XLEN-1:0]   asm_reg, asm_next;
    logic [`XLEN-1:0]   count_reg, count_next;
    logic [`XLEN-1:0]   word_idx_reg, word_idx_next;
    logic               wr_en_reg, wr_en_next;
    logic [`XLEN-1:0]   addr_reg, addr_next;
    logic [`XLEN-1:0]   wr_data_reg, wr_data_next;
    logic               cpu_rstn_reg, cpu_rstn_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
    logic [7:0]         sum_reg, sum_next;
`endif

    logic               ready;
    logic               accept;
    logic               word_full;
    logic [`XLEN-1:0]   full_word;

`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
    localparam loader_state_t ST_TAIL = ST_CHK;
    assign ready = (state_reg == ST_HDR) || (state_reg == ST_DATA) || (state_reg == ST_CHK);
`else
    localparam loader_state_t ST_TAIL = ST_DONE;
    assign ready = (state_reg == ST_HDR) || (state_reg == ST_DATA);
`endif

    assign accept    = bus.i_loader_valid && ready;
    assign word_full = accept && (byte_cnt_reg == LAST_BYTE);
    // Bytes shift in from the top so the first byte ends up in bits [7:0].
    assign full_word = {bus.i_loader_byte, asm_reg[`XLEN-1:8]};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        asm_next      = asm_reg;
        count_next    = count_reg;
        word_idx_next = word_idx_reg;
        wr_en_next    = 1'b0;
        addr_next     = addr_reg;
        wr_data_next  = wr_data_reg;
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
        sum_next      = sum_reg;
`endif

        if (accept) begin
            asm_next      = full_word;
            byte_cnt_next = byte_cnt_reg + 2'd1;
        end

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.i_loader_start) begin
                    state_next    = ST_HDR;
                    byte_cnt_next = 2'd0;
                end
            end
            ST_HDR: begin
                if (word_full) begin
                    count_next    = full_word;
                    word_idx_next = '0;
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
                    sum_next      = 8'h00;
`endif
                    if (full_word == '0) begin
                        state_next = ST_TAIL;
                    end else if (full_word > MAX_WORDS_W) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
                if (accept) begin
                    sum_next = sum_reg + bus.i_loader_byte;
                end
`endif
                // The strobe lands one cycle after the 4th byte; acceptance keeps going.
                if (word_full) begin
                    wr_en_next    = 1'b1;
                    wr_data_next  = full_word;
                    addr_next     = word_byte_addr(LOAD_BASE, word_idx_reg);
                    word_idx_next = word_idx_reg + 1'b1;
                    if (word_idx_reg == count_reg - 1'b1) begin
                        state_next = ST_TAIL;
                    end
                end
            end
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_next = (bus.i_loader_byte == sum_reg) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        cpu_rstn_next = (state_next == ST_DONE);
        done_next     = (state_next == ST_DONE);
        err_next      = (state_next == ST_ERR);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            byte_cnt_reg <= '0;
            asm_reg      <= '0;
            count_reg    <= '0;
            word_idx_reg <= '0;
            wr_en_reg    <= 1'b0;
            addr_reg     <= '0;
            wr_data_reg  <= '0;
            cpu_rstn_reg <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
            sum_reg      <= 8'h00;
`endif
        end else begin
            byte_cnt_reg <= byte_cnt_next;
            asm_reg      <= asm_next;
            count_reg    <= count_next;
            word_idx_reg <= word_idx_next;
            wr_en_reg    <= wr_en_next;
            addr_reg     <= addr_next;
            wr_data_reg  <= wr_data_next;
            cpu_rstn_reg <= cpu_rstn_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
            sum_reg      <= sum_next;
`endif
        end
    end

    assign bus.o_loader_ready        = ready;
    assign bus.o_loader_imem_wr_en   = wr_en_reg;
    assign bus.o_loader_imem_addr    = addr_reg;
    assign bus.o_loader_imem_wr_data = wr_data_reg;
    assign bus.o_loader_cpu_rstn     = cpu_rstn_reg;
    assign bus.o_loader_done         = done_reg;
    assign bus.o_loader_err          = err_reg;

endmodule
